// File: rtl/aqua_actuator_sequencer.sv
// aqua_actuator_sequencer
//
// Sits between the aquaculture mode FSM and the actuator drivers. It turns
// the six request bits into registered drive outputs under three rules:
// staggered turn-ons (inrush limiting), a per-actuator minimum on-time, and
// a periodic feed window that gates the feeder. A latched emergency trip
// forces every actuator off until software clears it.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   en       - enable; low pauses the block (no new turn-ons, feed counter frozen)
//   estop    - emergency stop, level-sensitive, sampled on clk
//   clr      - single-cycle trip clear
//   req[5:0] - requests: 0 aerator, 1 pump, 2 valve, 3 uv, 4 heater, 5 feeder
//   drv[5:0] - registered actuator drives, same bit order as req
//   settling - high while the stagger counter is non-zero
//   feed_win - feed window open
//   tripped  - block is in TRIP
module aqua_actuator_sequencer #(
   parameter int STAGGER     = 4,
   parameter int MIN_ON      = 8,
   parameter int FEED_PERIOD = 32,
   parameter int FEED_LEN    = 6,
   parameter int CW          = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       estop,
   input  logic       clr,
   input  logic [5:0] req,
   output logic [5:0] drv,
   output logic       settling,
   output logic       feed_win,
   output logic       tripped
);

   typedef enum logic [1:0] {RUN, PAUSE, TRIP} state_t;

   state_t        state;
   logic [CW-1:0] scnt;
   logic [CW-1:0] fcnt;
   logic [CW-1:0] ocnt [5];

   logic          win_now;
   logic [5:0]    eff_req;
   logic [5:0]    pending;
   logic [5:0]    grant;
   logic [5:0]    off;
   logic [CW-1:0] scnt_nxt;

   always_comb begin
      // The window the feeder sees on this edge comes straight from fcnt so a
      // held feeder request is granted on the very edge the window opens.
      win_now = (state == RUN) && (fcnt < CW'(FEED_LEN));
      eff_req = {req[5] & win_now, req[4:0]};
      pending = eff_req & ~drv;

      // Isolate the lowest set pending bit: aerator wins, feeder loses.
      grant = '0;
      if (state == RUN && scnt == '0)
         grant = pending & (~pending + 6'd1);

      // Turn-off candidates; the feeder has no minimum on-time.
      off = '0;
      for (int i = 0; i < 5; i++)
         off[i] = drv[i] & ~eff_req[i] & (ocnt[i] == '0);
      off[5] = drv[5] & ~eff_req[5];

      if (grant != '0)
         scnt_nxt = CW'(STAGGER - 1);
      else if (scnt != '0)
         scnt_nxt = scnt - CW'(1);
      else
         scnt_nxt = scnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         drv      <= '0;
         scnt     <= '0;
         fcnt     <= '0;
         settling <= 1'b0;
         feed_win <= 1'b0;
         tripped  <= 1'b0;
         for (int i = 0; i < 5; i++)
            ocnt[i] <= '0;
      end else if (estop) begin
         // Trip entry (or staying tripped): everything off, MIN_ON ignored.
         state    <= TRIP;
         drv      <= '0;
         scnt     <= '0;
         fcnt     <= '0;
         settling <= 1'b0;
         feed_win <= 1'b0;
         tripped  <= 1'b1;
         for (int i = 0; i < 5; i++)
            ocnt[i] <= '0;
      end else begin
         case (state)
            TRIP: begin
               // Outputs and counters already zero; only a clear leaves.
               if (clr) begin
                  state   <= en ? RUN : PAUSE;
                  tripped <= 1'b0;
               end
            end
            default: begin
               // RUN and PAUSE share turn-off and decrement behaviour; grant
               // is already zero outside RUN.
               state    <= en ? RUN : PAUSE;
               drv      <= (drv & ~off) | grant;
               scnt     <= scnt_nxt;
               settling <= (scnt_nxt != '0);
               feed_win <= win_now;
               for (int i = 0; i < 5; i++) begin
                  if (grant[i])
                     ocnt[i] <= CW'(MIN_ON - 1);
                  else if (drv[i] && ocnt[i] != '0)
                     ocnt[i] <= ocnt[i] - CW'(1);
               end
               if (state == RUN)
                  fcnt <= (fcnt == CW'(FEED_PERIOD - 1)) ? '0 : fcnt + CW'(1);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aqua_actuator_sequencer.sv
module tb_aqua_actuator_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       estop = 1'b0;
   logic       clr = 1'b0;
   logic [5:0] req = '0;
   logic [5:0] drv;
   logic       settling;
   logic       feed_win;
   logic       tripped;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [5:0] drv;
      logic       set;
      logic       fw;
      logic       trip;
   } exp_t;

   exp_t sb[$];

   aqua_actuator_sequencer #(
      .STAGGER(4), .MIN_ON(8), .FEED_PERIOD(32), .FEED_LEN(6), .CW(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .estop(estop), .clr(clr),
      .req(req), .drv(drv), .settling(settling), .feed_win(feed_win),
      .tripped(tripped)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, got, want);
      end
   endtask

   // Starts and ends at a falling edge: drive inputs, queue the expectation,
   // let one rising edge happen, then pop and compare.
   task automatic step(input string tag, input logic [5:0] r, input logic e,
                       input logic es, input logic c, input logic [5:0] xd,
                       input logic xs, input logic xf, input logic xt);
      exp_t x;
      req = r; en = e; estop = es; clr = c;
      x.tag = tag; x.drv = xd; x.set = xs; x.fw = xf; x.trip = xt;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk({x.tag, ".drv"}, drv, x.drv);
      chk({x.tag, ".settling"}, {5'b0, settling}, {5'b0, x.set});
      chk({x.tag, ".feed_win"}, {5'b0, feed_win}, {5'b0, x.fw});
      chk({x.tag, ".tripped"}, {5'b0, tripped}, {5'b0, x.trip});
      @(negedge clk);
   endtask

   // Called at a falling edge; asserts reset away from any rising edge and
   // checks the outputs respond without a clock.
   task automatic do_reset(input string tag);
      req = '0; en = 1'b0; estop = 1'b0; clr = 1'b0;
      rst_n = 1'b0;
      #2;
      chk({tag, ".drv"}, drv, 6'b0);
      chk({tag, ".settling"}, {5'b0, settling}, 6'b0);
      chk({tag, ".feed_win"}, {5'b0, feed_win}, 6'b0);
      chk({tag, ".tripped"}, {5'b0, tripped}, 6'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [5:0] r;
      logic       es, c;
      int         k;

      @(negedge clk);
      do_reset("rst_init");

      // Stagger: three held requests granted 4 edges apart.
      for (int e = 0; e < 12; e++)
         step($sformatf("stag%0d", e), 6'b000111, 1'b1, 1'b0, 1'b0,
              {3'b0, 1'(e >= 8), 1'(e >= 4), 1'b1}, (e % 4) <= 2, e < 6, 1'b0);

      // Minimum on-time with a 2-edge request pulse.
      do_reset("rst_minon");
      for (int e = 0; e < 10; e++)
         step($sformatf("minon%0d", e), (e <= 1) ? 6'b000001 : 6'b000000,
              1'b1, 1'b0, 1'b0, {5'b0, 1'(e <= 7)}, e <= 2, e < 6, 1'b0);

      // Request drops and returns while still inside the min-on time.
      do_reset("rst_rereq");
      for (int e = 0; e < 14; e++)
         step($sformatf("rereq%0d", e),
              (e <= 1 || (e >= 5 && e <= 12)) ? 6'b000001 : 6'b000000,
              1'b1, 1'b0, 1'b0, {5'b0, 1'(e <= 12)}, e <= 2, e < 6, 1'b0);

      // Priority: pump, valve, heater appearing together.
      do_reset("rst_prio");
      for (int e = 0; e < 17; e++)
         step($sformatf("prio%0d", e), (e >= 5) ? 6'b010110 : 6'b000000,
              1'b1, 1'b0, 1'b0,
              {1'b0, 1'(e >= 13), 1'b0, 1'(e >= 9), 1'(e >= 5), 1'b0},
              (e >= 5) && (((e - 5) % 4) <= 2), e < 6, 1'b0);

      // Feed window across a full period and the reopening.
      do_reset("rst_feed");
      for (int e = 0; e < 34; e++)
         step($sformatf("feed%0d", e), 6'b100000, 1'b1, 1'b0, 1'b0,
              {1'((e % 32) < 6), 5'b0}, (e % 32) <= 2, (e % 32) < 6, 1'b0);

      // Ten paused edges shift the next window by ten.
      do_reset("rst_fpause");
      for (int e = 0; e < 44; e++)
         step($sformatf("fpause%0d", e), 6'b100000, !(e >= 10 && e <= 19),
              1'b0, 1'b0, {1'((e < 6) || (e >= 42)), 5'b0},
              (e <= 2) || (e >= 42), (e < 6) || (e >= 42), 1'b0);

      // Trip with four actuators on and the aerator mid min-on.
      do_reset("rst_trip");
      for (int e = 0; e < 35; e++) begin
         es = (e == 15 || e == 16);
         c  = (e == 16 || e == 20);
         if (e < 12 || e == 13 || e == 14 || e == 15) r = 6'b001110;
         else r = 6'b001111;
         if (e <= 14)
            step($sformatf("trip%0d", e), r, 1'b1, es, c,
                 {2'b0, 1'(e >= 8), 1'(e >= 4), 1'b1, 1'(e >= 12)},
                 (e % 4) <= 2, e < 6, 1'b0);
         else if (e <= 19)
            step($sformatf("trip%0d", e), r, 1'b1, es, c, 6'b0, 1'b0, 1'b0, 1'b1);
         else if (e == 20)
            step($sformatf("trip%0d", e), r, 1'b1, es, c, 6'b0, 1'b0, 1'b0, 1'b0);
         else begin
            k = e - 21;
            step($sformatf("trip%0d", e), r, 1'b1, es, c,
                 {2'b0, 1'(k >= 12), 1'(k >= 8), 1'(k >= 4), 1'b1},
                 (k % 4) <= 2, k < 6, 1'b0);
         end
      end

      // Asynchronous reset in the middle of a stagger interval.
      do_reset("rst_mid0");
      for (int e = 0; e < 2; e++)
         step($sformatf("mid%0d", e), 6'b000011, 1'b1, 1'b0, 1'b0,
              6'b000001, 1'b1, 1'b1, 1'b0);
      do_reset("rst_mid");
      for (int e = 0; e < 5; e++)
         step($sformatf("after%0d", e), 6'b000011, 1'b1, 1'b0, 1'b0,
              {4'b0, 1'(e >= 4), 1'b1}, (e % 4) <= 2, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
